fadd_sub_bist: RTL and testbench
================================

Name: fadd_sub_bist

Overview:
- Self-checking sweep engine that drives the 4-bit adder/subtractor (fadd_sub_bh) and checks its outputs.
- It generates every (a, b, control) combination, waits a settle time, then samples sum/carry and compares them against an internal golden model.
- Counts mismatches and captures the first failing vector.
- Sits beside the adder/subtractor as its built-in self-test controller.

Parameters:
- WIDTH, 4, operand width of the adder/subtractor under test.
- SETTLE, 1, cycles (>=1) between driving a vector and sampling the DUT outputs.
- ERR_W, 16, width of the error counter (saturating).
- CARRY_IS_BORROW, 0, subtract carry convention: 0 = two's-complement carry (1 when a>=b); 1 = borrow (1 when a<b).

Ports:
- clk_in  input  1  clock, rising edge.
- reset_in  input  1  synchronous, active-high reset.
- start_in  input  1  pulse; starts a sweep when in IDLE or DONE.
- a_out  output  WIDTH  operand A to DUT a_in.
- b_out  output  WIDTH  operand B to DUT b_in.
- control_out  output  1  to DUT control_in; 0 = add, 1 = subtract.
- sum_in  input  WIDTH  from DUT sum_out.
- carry_in  input  1  from DUT carry_out.
- busy_out  output  1  sweep in progress.
- done_out  output  1  sweep complete; held until next start or reset.
- pass_out  output  1  done_out and err_count_out==0.
- err_count_out  output  ERR_W  mismatching vectors, saturates at all-ones.
- fail_a_out  output  WIDTH  A of first failing vector.
- fail_b_out  output  WIDTH  B of first failing vector.
- fail_control_out  output  1  control of first failing vector.
- fail_valid_out  output  1  a first failure has been captured.

Behaviour:
- Single clock domain. One clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset value of every output: 0. Reset forces IDLE.
- Reset mid-sweep aborts the sweep; all outputs are 0 after that edge.
- States:
  - IDLE: start_in=1 → RUN. On the same edge: vector index=0, settle cnt=0, errors/fail regs cleared, busy=1, done=0.
  - RUN: every cycle cnt increments. When cnt==SETTLE (compare cycle):
    - sample sum_in/carry_in, compare, cnt←0, advance vector.
    - if this was the last vector → DONE: busy=0, done=1, a/b/control_out←0.
  - DONE: outputs hold. start_in=1 → RUN, behaving exactly as from IDLE.
- start_in is ignored in RUN.
- Sweep order matches nested loops: control innermost, then b, a outermost.
  - Vector index i = {a, b, control}, WIDTH+WIDTH+1 bits, i = 0 .. 2^(2*WIDTH+1)-1.
  - Advancing past the last vector wraps and ends the sweep.
- Each vector is presented for SETTLE+1 cycles. Sweep length is 2^(2*WIDTH+1)*(SETTLE+1) cycles; done_out rises on that edge after start is accepted (1024 for defaults).
- Golden model, computed at WIDTH+1 bits:
  - add: {carry, sum} = a + b.
  - subtract: {c, sum} = a + ~b + 1; carry = c when CARRY_IS_BORROW=0, else ~c.
- Mismatch: sum_in or carry_in differs from golden.
  - On mismatch: err_count increments unless already saturated.
  - On the first mismatch: fail_a/b/control_out captured and fail_valid=1. Later mismatches do not update the capture.
- pass_out = done & (err_count==0), registered, so it is valid in the same cycle as done_out.

Test Plan:
- Correct DUT, defaults, start pulse at edge k → busy 1 for cycles k..k+1023. At edge k+1024: done=1, pass=1, err=0, fail_valid=0, a/b/control_out=0.
- Sum bit0 stuck-at-0 → err=256, pass=0, first fail a=0, b=1, control=0.
- Carry forced 0 only when subtracting, CARRY_IS_BORROW=0 → err=136 (subtract vectors with a>=b), first fail a=0, b=0, control=1.
- Correct DUT using borrow convention, checked with CARRY_IS_BORROW=0 → err=256 (every subtract vector). Same DUT with CARRY_IS_BORROW=1 → err=0, pass=1.
- ERR_W=4 with the sum-bit0 fault → err_count saturates at 15; fail capture still shows a=0, b=1, control=0.
- Abort and restart:
  - reset_in high for one cycle at cycle 300 of a sweep → next edge all outputs 0 and state IDLE. A new start then gives a full 1024-cycle sweep.
  - start_in re-pulsed at cycle 500 while busy → ignored; done still at cycle 1024.

Source files
------------

// File: rtl/fadd_sub_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : fadd_sub_bist_if
// Brief    : Start/status bundle plus the stimulus/response bus between the
//            BIST sweep engine and the adder/subtractor it exercises.
// Revision : 1.0
// ============================================================================
interface fadd_sub_bist_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 16
);
    logic             start_in;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             control_out;
    logic [WIDTH-1:0] sum_in;
    logic             carry_in;
    logic             busy_out;
    logic             done_out;
    logic             pass_out;
    logic [ERR_W-1:0] err_count_out;
    logic [WIDTH-1:0] fail_a_out;
    logic [WIDTH-1:0] fail_b_out;
    logic             fail_control_out;
    logic             fail_valid_out;

    modport master (
        input  start_in, sum_in, carry_in,
        output a_out, b_out, control_out, busy_out, done_out, pass_out,
               err_count_out, fail_a_out, fail_b_out, fail_control_out,
               fail_valid_out
    );

    modport slave (
        output start_in, sum_in, carry_in,
        input  a_out, b_out, control_out, busy_out, done_out, pass_out,
               err_count_out, fail_a_out, fail_b_out, fail_control_out,
               fail_valid_out
    );
endinterface
`default_nettype wire

// File: rtl/fadd_sub_bist.sv
`default_nettype none
// ============================================================================
// Module   : fadd_sub_bist
// Brief    : Exhaustive sweep/compare self-test controller for a WIDTH-bit
//            adder/subtractor; counts mismatches and latches the first one.
// Revision : 1.0
// ============================================================================
module fadd_sub_bist #(
    parameter int WIDTH           = 4,
    parameter int SETTLE          = 1,
    parameter int ERR_W           = 16,
    parameter int CARRY_IS_BORROW = 0
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    fadd_sub_bist_if.master      bus
);
    localparam int                 c_idx_w   = 2 * WIDTH + 1;
    localparam int                 c_cnt_w   = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [c_cnt_w-1:0] c_settle  = c_cnt_w'(SETTLE);
    localparam logic [ERR_W-1:0]   c_err_max = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_idx_w-1:0] r_idx;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err;
    logic [WIDTH-1:0]   r_fail_a;
    logic [WIDTH-1:0]   r_fail_b;
    logic               r_fail_c;
    logic               r_fail_v;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_c;
    logic [WIDTH:0]     w_gold;
    logic               w_gold_carry;
    logic               w_mismatch;
    logic [ERR_W-1:0]   w_err_next;
    logic               w_sample;
    logic               w_last;

    // Vector index packs {a, b, control}; control toggles fastest.
    assign w_a = r_idx[c_idx_w-1 -: WIDTH];
    assign w_b = r_idx[WIDTH:1];
    assign w_c = r_idx[0];

    assign w_gold = w_c ? ({1'b0, w_a} + {1'b0, ~w_b} + (WIDTH+1)'(1))
                        : ({1'b0, w_a} + {1'b0, w_b});
    assign w_gold_carry = (w_c && (CARRY_IS_BORROW != 0)) ? ~w_gold[WIDTH] : w_gold[WIDTH];

    assign w_mismatch = (bus.sum_in != w_gold[WIDTH-1:0]) || (bus.carry_in != w_gold_carry);
    assign w_err_next = (w_mismatch && (r_err != c_err_max)) ? r_err + ERR_W'(1) : r_err;
    assign w_sample   = (r_cnt == c_settle);
    assign w_last     = &r_idx;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_fail_a <= '0;
            r_fail_b <= '0;
            r_fail_c <= 1'b0;
            r_fail_v <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start_in) begin
                        r_state  <= S_RUN;
                        r_idx    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_err    <= '0;
                        r_fail_a <= '0;
                        r_fail_b <= '0;
                        r_fail_c <= 1'b0;
                        r_fail_v <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_sample) begin
                        r_cnt <= '0;
                        // Wrapping past the last vector also parks a/b/control at 0.
                        r_idx <= r_idx + c_idx_w'(1);
                        r_err <= w_err_next;
                        if (w_mismatch && !r_fail_v) begin
                            r_fail_a <= w_a;
                            r_fail_b <= w_b;
                            r_fail_c <= w_c;
                            r_fail_v <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.a_out            = w_a;
    assign bus.b_out            = w_b;
    assign bus.control_out      = w_c;
    assign bus.busy_out         = r_busy;
    assign bus.done_out         = r_done;
    assign bus.pass_out         = r_pass;
    assign bus.err_count_out    = r_err;
    assign bus.fail_a_out       = r_fail_a;
    assign bus.fail_b_out       = r_fail_b;
    assign bus.fail_control_out = r_fail_c;
    assign bus.fail_valid_out   = r_fail_v;
endmodule
`default_nettype wire

// File: tb/tb_fadd_sub_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_fadd_sub_bist
// Brief    : Bench for three BIST variants sharing one clock/reset/start and a
//            modelled adder/subtractor with selectable faults.
// Revision : 1.0
// ============================================================================
module tb_fadd_sub_bist;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    int   fault_mode = 0;
    bit   chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fadd_sub_bist_if #(.WIDTH(4), .ERR_W(16)) if0 ();
    fadd_sub_bist_if #(.WIDTH(4), .ERR_W(16)) if1 ();
    fadd_sub_bist_if #(.WIDTH(4), .ERR_W(4))  if2 ();

    fadd_sub_bist #(.WIDTH(4), .SETTLE(1), .ERR_W(16), .CARRY_IS_BORROW(0))
        u0 (.clk_in(clk), .reset_in(rst), .bus(if0.master));
    fadd_sub_bist #(.WIDTH(4), .SETTLE(1), .ERR_W(16), .CARRY_IS_BORROW(1))
        u1 (.clk_in(clk), .reset_in(rst), .bus(if1.master));
    fadd_sub_bist #(.WIDTH(4), .SETTLE(1), .ERR_W(4), .CARRY_IS_BORROW(0))
        u2 (.clk_in(clk), .reset_in(rst), .bus(if2.master));

    // Adder/subtractor under test: mode 0 correct, 1 sum bit0 stuck-at-0,
    // 2 carry forced 0 on subtract, 3 borrow-convention subtractor.
    function automatic logic [4:0] dut_adder(input logic [3:0] a, input logic [3:0] b,
                                             input logic c, input int mode);
        int s;
        logic cy;
        if (!c) begin
            s  = int'(a) + int'(b);
            cy = (s >= 16);
        end else begin
            s  = (int'(a) - int'(b) + 16) % 16;
            cy = (a >= b);
            if (mode == 2) cy = 1'b0;
            if (mode == 3) cy = (a < b);
        end
        if (mode == 1) s = s & 14;
        return {cy, 4'(s)};
    endfunction

    function automatic logic [4:0] golden(input int a, input int b, input int c, input int cib);
        if (c == 0) return {(a + b) >= 16, 4'((a + b) % 16)};
        return {(cib != 0) ? (a < b) : (a >= b), 4'((a - b + 16) % 16)};
    endfunction

    assign if0.start_in = start;
    assign if1.start_in = start;
    assign if2.start_in = start;
    always_comb {if0.carry_in, if0.sum_in} = dut_adder(if0.a_out, if0.b_out, if0.control_out, fault_mode);
    always_comb {if1.carry_in, if1.sum_in} = dut_adder(if1.a_out, if1.b_out, if1.control_out, fault_mode);
    always_comb {if2.carry_in, if2.sum_in} = dut_adder(if2.a_out, if2.b_out, if2.control_out, fault_mode);

    // Packed observation: busy,done,pass,fv,fa,fb,fc,a,b,c,err16
    logic [38:0] act [3];
    assign act[0] = {if0.busy_out, if0.done_out, if0.pass_out, if0.fail_valid_out, if0.fail_a_out,
                     if0.fail_b_out, if0.fail_control_out, if0.a_out, if0.b_out, if0.control_out,
                     if0.err_count_out};
    assign act[1] = {if1.busy_out, if1.done_out, if1.pass_out, if1.fail_valid_out, if1.fail_a_out,
                     if1.fail_b_out, if1.fail_control_out, if1.a_out, if1.b_out, if1.control_out,
                     if1.err_count_out};
    assign act[2] = {if2.busy_out, if2.done_out, if2.pass_out, if2.fail_valid_out, if2.fail_a_out,
                     if2.fail_b_out, if2.fail_control_out, if2.a_out, if2.b_out, if2.control_out,
                     16'(if2.err_count_out)};

    // ---------------- behavioural model ----------------
    localparam int NVEC = 512;
    localparam int SWEEP = 1024;
    int cib_of [3] = '{0, 1, 0};
    int max_of [3] = '{65535, 65535, 15};
    int prefix [3][NVEC+1];
    int first_fail [3];
    int fin_err [3];
    int fin_first [3];
    int m_state = 0;  // 0 idle, 1 running, 2 done
    int m_j = 0;      // clock edges since start accepted

    task automatic compute_model();
        for (int k = 0; k < 3; k++) begin
            int p = 0;
            first_fail[k] = NVEC;
            prefix[k][0] = 0;
            for (int n = 0; n < NVEC; n++) begin
                int a = n / 32;
                int b = (n / 2) % 16;
                int c = n % 2;
                if (dut_adder(4'(a), 4'(b), c[0], fault_mode) != golden(a, b, c, cib_of[k])) begin
                    if (first_fail[k] == NVEC) first_fail[k] = n;
                    p++;
                end
                prefix[k][n+1] = p;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_state <= 0;
            m_j     <= 0;
        end else if (m_state != 1) begin
            if (start) begin
                m_state <= 1;
                m_j     <= 0;
            end
        end else begin
            m_j <= m_j + 1;
            if (m_j + 1 == SWEEP) begin
                m_state <= 2;
                for (int k = 0; k < 3; k++) begin
                    fin_err[k]   <= prefix[k][NVEC];
                    fin_first[k] <= first_fail[k];
                end
            end
        end
    end

    function automatic logic [38:0] exp_vec(input int k);
        int busy = 0, done = 0, pass = 0, fv = 0, ff = 0, n = 0, err = 0, vec = 0;
        if (m_state == 1) begin
            n    = m_j / 2;
            busy = 1;
            vec  = n;
            err  = (prefix[k][n] > max_of[k]) ? max_of[k] : prefix[k][n];
            fv   = (first_fail[k] < n) ? 1 : 0;
            ff   = first_fail[k];
        end else if (m_state == 2) begin
            done = 1;
            err  = (fin_err[k] > max_of[k]) ? max_of[k] : fin_err[k];
            fv   = (fin_first[k] < NVEC) ? 1 : 0;
            ff   = fin_first[k];
            pass = (fin_err[k] == 0) ? 1 : 0;
        end
        if (fv == 0) ff = 0;
        return {busy[0], done[0], pass[0], fv[0], 4'(ff / 32), 4'((ff / 2) % 16), ff[0],
                4'(vec / 32), 4'((vec / 2) % 16), vec[0], 16'(err)};
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                logic [38:0] e;
                e = exp_vec(k);
                n_cmp++;
                if (act[k] !== e) begin
                    n_bad++;
                    $display("FAIL inst%0d_outputs: got %h, want %h (t=%0t)", k, act[k], e, $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_sweep(input int mode, input int repoke, output int cyc);
        fault_mode = mode;
        compute_model();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!if0.done_out && cyc < 1100) begin
            if (cyc == repoke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        check("sweep_len", cyc, SWEEP);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", int'(if0.busy_out), 0);
        check("reset_err", int'(if0.err_count_out), 0);

        run_sweep(0, -1, cyc);
        check("ok_pass", int'(if0.pass_out), 1);
        check("ok_fail_valid", int'(if0.fail_valid_out), 0);
        check("ok_a_out", int'(if0.a_out), 0);

        run_sweep(1, -1, cyc);
        check("sa0_err", int'(if0.err_count_out), 256);
        check("sa0_pass", int'(if0.pass_out), 0);
        check("sa0_fail_abc", int'({if0.fail_a_out, if0.fail_b_out, if0.fail_control_out}), 9'h002);
        check("sat_err", int'(if2.err_count_out), 15);
        check("sat_fail_abc", int'({if2.fail_a_out, if2.fail_b_out, if2.fail_control_out}), 9'h002);

        run_sweep(2, -1, cyc);
        check("sub_carry_err", int'(if0.err_count_out), 136);
        check("sub_carry_fail_abc", int'({if0.fail_a_out, if0.fail_b_out, if0.fail_control_out}), 9'h001);

        run_sweep(3, -1, cyc);
        check("borrow_vs_cib0_err", int'(if0.err_count_out), 256);
        check("borrow_vs_cib1_err", int'(if1.err_count_out), 0);
        check("borrow_vs_cib1_pass", int'(if1.pass_out), 1);

        // Abort mid-sweep with reset, then a fresh full sweep.
        fault_mode = 1;
        compute_model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(if0.busy_out), 0);
        check("abort_err", int'(if0.err_count_out), 0);
        check("abort_fail_valid", int'(if0.fail_valid_out), 0);
        run_sweep(1, -1, cyc);
        check("after_abort_err", int'(if0.err_count_out), 256);

        // start re-pulsed while busy must be ignored.
        run_sweep(0, 500, cyc);
        check("repulse_pass", int'(if0.pass_out), 1);

        for (int r = 0; r < 2; r++) begin
            run_sweep(int'($urandom_range(0, 3)), int'($urandom_range(1, 1000)), cyc);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
